// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the accumulator CPU execute slice.
//   - Default datapath width (W) and input-port width (IW)
//   - Bit positions of the ALU strobes inside the packed strobe vector
//   - Opcode indices of the D one-hot produced by the 4-to-16 decoder
package alu_exec_unit_pkg;

    localparam int W_DEF  = 32;
    localparam int IW_DEF = 8;

    // ALU strobe positions, listed in descending priority (index 0 wins).
    localparam int ALU_AND  = 0;
    localparam int ALU_ADD  = 1;
    localparam int ALU_DR   = 2;
    localparam int ALU_INPR = 3;
    localparam int ALU_CMP  = 4;
    localparam int ALU_SHR  = 5;
    localparam int ALU_SHL  = 6;
    localparam int ALU_MUL  = 7;
    localparam int ALU_DIV  = 8;
    localparam int ALU_N    = 9;

    // Opcode indices on the D one-hot.
    localparam int D_AND = 0;
    localparam int D_ADD = 1;
    localparam int D_LDA = 2;
    localparam int D_STA = 3;
    localparam int D_BUN = 4;
    localparam int D_BSA = 5;
    localparam int D_ISZ = 6;
    localparam int D_REG = 7;
    localparam int D_MUL = 8;
    localparam int D_DIV = 9;

endpackage

// File: rtl/alu_exec_unit_alu.sv
// Combinational ALU of the execute slice. Owns the fixed-priority strobe mux.
// Ports:
//   ac, e      in   current accumulator / link register
//   dr         in   memory operand
//   inpr       in   input-port data (replaces ac[IW-1:0])
//   op         in   packed ALU strobes, bit positions from alu_exec_unit_pkg
//   e_clr      in   clear E (ignored when add/shr/shl owns E)
//   e_cmp      in   complement E (e_clr wins if both are high)
//   ac_nxt     out  ALU result
//   e_nxt      out  next E
module alu
    import alu_exec_unit_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic [W-1:0]     ac,
    input  logic             e,
    input  logic [W-1:0]     dr,
    input  logic [IW-1:0]    inpr,
    input  logic [ALU_N-1:0] op,
    input  logic             e_clr,
    input  logic             e_cmp,
    output logic [W-1:0]     ac_nxt,
    output logic             e_nxt
);

    logic [W:0]   sum;
    logic [W-1:0] prod;
    logic [W-1:0] quo;

    assign sum  = {1'b0, ac} + {1'b0, dr};
    assign prod = ac * dr;
    // Divide by zero saturates to all ones instead of being undefined.
    assign quo  = (dr == '0) ? '1 : ac / dr;

    always_comb begin
        ac_nxt = ac;
        // E default path; add/shr/shl overwrite it below when they win.
        if (e_clr)
            e_nxt = 1'b0;
        else if (e_cmp)
            e_nxt = ~e;
        else
            e_nxt = e;

        if (op[ALU_AND]) begin
            ac_nxt = ac & dr;
        end else if (op[ALU_ADD]) begin
            {e_nxt, ac_nxt} = sum;
        end else if (op[ALU_DR]) begin
            ac_nxt = dr;
        end else if (op[ALU_INPR]) begin
            ac_nxt[IW-1:0] = inpr;
        end else if (op[ALU_CMP]) begin
            ac_nxt = ~ac;
        end else if (op[ALU_SHR]) begin
            ac_nxt = {e, ac[W-1:1]};
            e_nxt  = ac[0];
        end else if (op[ALU_SHL]) begin
            ac_nxt = {ac[W-2:0], e};
            e_nxt  = ac[W-1];
        end else if (op[ALU_MUL]) begin
            ac_nxt = prod;
        end else if (op[ALU_DIV]) begin
            ac_nxt = quo;
        end
    end

endmodule

// File: rtl/alu_exec_unit_dec.sv
// Timing and opcode decoders of the execute slice (purely combinational).
// Ports (both modules):
//   in   in   binary select (SC or {ir16, ir14:12})
//   en   in   decoder enable; low forces all outputs to zero
//   out  out  one-hot, out[k]=1 iff en and in==k
module dec_3to8 (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    assign out = en ? (8'd1 << in) : 8'd0;

endmodule

module dec_4to16 (
    input  logic [3:0]  in,
    input  logic        en,
    output logic [15:0] out
);

    assign out = en ? (16'd1 << in) : 16'd0;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute slice of the 32-bit accumulator CPU: AC/E registers around the
// combinational ALU, plus the SC->T and opcode->D decoders.
// Ports:
//   clk, com_rst         clock, synchronous active-high reset (clears AC/E)
//   en                   register update enable (decoders stay live)
//   dr, inpr             memory operand, input-port data
//   op_*                 ALU strobes (and, add, dr, inpr, cmp, shr, shl, mul, div)
//   e_clr, e_cmp         E clear / complement
//   ac_clr, ac_inr       AC clear / increment
//   sc, dcode, dec_en    decoder inputs
//   ac, e                registered accumulator / link
//   ac_nxt, e_nxt        combinational ALU result / next E
//   t, d                 timing and opcode one-hots
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          com_rst,
    input  logic          en,
    input  logic [W-1:0]  dr,
    input  logic [IW-1:0] inpr,
    input  logic          op_and,
    input  logic          op_add,
    input  logic          op_dr,
    input  logic          op_inpr,
    input  logic          op_cmp,
    input  logic          op_shr,
    input  logic          op_shl,
    input  logic          op_mul,
    input  logic          op_div,
    input  logic          e_clr,
    input  logic          e_cmp,
    input  logic          ac_clr,
    input  logic          ac_inr,
    input  logic [2:0]    sc,
    input  logic [3:0]    dcode,
    input  logic          dec_en,
    output logic [W-1:0]  ac,
    output logic          e,
    output logic [W-1:0]  ac_nxt,
    output logic          e_nxt,
    output logic [7:0]    t,
    output logic [15:0]   d
);

    logic [ALU_N-1:0] op;

    always_comb begin
        op           = '0;
        op[ALU_AND]  = op_and;
        op[ALU_ADD]  = op_add;
        op[ALU_DR]   = op_dr;
        op[ALU_INPR] = op_inpr;
        op[ALU_CMP]  = op_cmp;
        op[ALU_SHR]  = op_shr;
        op[ALU_SHL]  = op_shl;
        op[ALU_MUL]  = op_mul;
        op[ALU_DIV]  = op_div;
    end

    alu #(.W(W), .IW(IW)) u_alu (
        .ac     (ac),
        .e      (e),
        .dr     (dr),
        .inpr   (inpr),
        .op     (op),
        .e_clr  (e_clr),
        .e_cmp  (e_cmp),
        .ac_nxt (ac_nxt),
        .e_nxt  (e_nxt)
    );

    dec_3to8 u_dec_t (
        .in  (sc),
        .en  (dec_en),
        .out (t)
    );

    dec_4to16 u_dec_d (
        .in  (dcode),
        .en  (dec_en),
        .out (d)
    );

    // AC priority: clear, then any ALU strobe, then increment, else hold.
    // E always follows e_nxt while enabled, so an increment leaves it alone
    // unless e_clr/e_cmp ask otherwise.
    always_ff @(posedge clk) begin
        if (com_rst) begin
            ac <= '0;
            e  <= 1'b0;
        end else if (en) begin
            if (ac_clr)
                ac <= '0;
            else if (|op)
                ac <= ac_nxt;
            else if (ac_inr)
                ac <= ac + {{(W-1){1'b0}}, 1'b1};
            e <= e_nxt;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam int W  = 32;
    localparam int IW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          com_rst;
    logic          en;
    logic [W-1:0]  dr;
    logic [IW-1:0] inpr;
    logic [8:0]    ops;   // 0 and,1 add,2 dr,3 inpr,4 cmp,5 shr,6 shl,7 mul,8 div
    logic          e_clr, e_cmp, ac_clr, ac_inr;
    logic [2:0]    sc;
    logic [3:0]    dcode;
    logic          dec_en;
    logic [W-1:0]  ac, ac_nxt;
    logic          e, e_nxt;
    logic [7:0]    t;
    logic [15:0]   d;

    alu_exec_unit #(.W(W), .IW(IW)) dut (
        .clk     (clk),
        .com_rst (com_rst),
        .en      (en),
        .dr      (dr),
        .inpr    (inpr),
        .op_and  (ops[0]),
        .op_add  (ops[1]),
        .op_dr   (ops[2]),
        .op_inpr (ops[3]),
        .op_cmp  (ops[4]),
        .op_shr  (ops[5]),
        .op_shl  (ops[6]),
        .op_mul  (ops[7]),
        .op_div  (ops[8]),
        .e_clr   (e_clr),
        .e_cmp   (e_cmp),
        .ac_clr  (ac_clr),
        .ac_inr  (ac_inr),
        .sc      (sc),
        .dcode   (dcode),
        .dec_en  (dec_en),
        .ac      (ac),
        .e       (e),
        .ac_nxt  (ac_nxt),
        .e_nxt   (e_nxt),
        .t       (t),
        .d       (d)
    );

    // ---------------- scoreboard ----------------
    // comb_q: {ac_nxt, e_nxt, t, d} expected in the cycle the stimulus is applied
    // exp_q : {ac, e} expected after the following rising edge
    logic [W+24:0] comb_q[$];
    logic [W:0]    exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference state of the architectural registers.
    logic [W-1:0]  m_ac;
    logic          m_e;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Applies the ALU rules directly: the first strobe set in priority order
    // defines the result; E comes from add/shr/shl, otherwise from e_clr/e_cmp.
    task automatic commit();
        logic [W:0]      sum;
        logic [2*W-1:0]  prod;
        logic [W-1:0]    nxt;
        logic            ne;
        logic [7:0]      t_exp;
        logic [15:0]     d_exp;
        int              sel;
        bit              e_owned;

        sum  = {1'b0, m_ac} + {1'b0, dr};
        prod = {{W{1'b0}}, m_ac} * {{W{1'b0}}, dr};
        sel  = -1;
        for (int i = 0; i < 9; i++)
            if (ops[i] && sel < 0) sel = i;

        nxt = m_ac;
        ne  = m_e;
        e_owned = 1'b0;
        case (sel)
            0: nxt = m_ac & dr;
            1: begin nxt = sum[W-1:0]; ne = sum[W]; e_owned = 1'b1; end
            2: nxt = dr;
            3: nxt = (m_ac & ~{{(W-IW){1'b0}}, {IW{1'b1}}}) | {{(W-IW){1'b0}}, inpr};
            4: nxt = ~m_ac;
            5: begin nxt = (m_ac >> 1) | ({{(W-1){1'b0}}, m_e} << (W-1)); ne = m_ac[0]; e_owned = 1'b1; end
            6: begin nxt = (m_ac << 1) | {{(W-1){1'b0}}, m_e}; ne = m_ac[W-1]; e_owned = 1'b1; end
            7: nxt = prod[W-1:0];
            8: nxt = (dr == 0) ? {W{1'b1}} : m_ac / dr;
            default: nxt = m_ac;
        endcase
        if (!e_owned) begin
            if (e_clr)      ne = 1'b0;
            else if (e_cmp) ne = ~m_e;
        end

        for (int k = 0; k < 8; k++)  t_exp[k] = dec_en && (int'(sc) == k);
        for (int k = 0; k < 16; k++) d_exp[k] = dec_en && (int'(dcode) == k);

        comb_q.push_back({nxt, ne, t_exp, d_exp});

        if (com_rst) begin
            m_ac = '0;
            m_e  = 1'b0;
        end else if (en) begin
            if (ac_clr)       m_ac = '0;
            else if (sel >= 0) m_ac = nxt;
            else if (ac_inr)  m_ac = m_ac + 1;
            m_e = ne;
        end
        exp_q.push_back({m_ac, m_e});
    endtask

    // ---------------- driver ----------------
    task automatic begin_cycle();
        @(negedge clk);
        com_rst = 1'b0;
        en      = 1'b1;
        dr      = $urandom();
        inpr    = IW'($urandom());
        ops     = '0;
        e_clr   = 1'b0;
        e_cmp   = 1'b0;
        ac_clr  = 1'b0;
        ac_inr  = 1'b0;
        sc      = 3'($urandom());
        dcode   = 4'($urandom());
        dec_en  = 1'b1;
    endtask

    task automatic load_ac(input logic [W-1:0] v);
        begin_cycle();
        dr = v; ops[2] = 1'b1;
        commit();
    endtask

    task automatic do_op(input int idx, input logic [W-1:0] dr_v);
        begin_cycle();
        dr = dr_v; ops[idx] = 1'b1;
        commit();
    endtask

    // ---------------- monitors ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                logic [W+24:0] c;
                c = comb_q.pop_front();
                check("ac_nxt", ac_nxt, c[W+24:25]);
                check("e_nxt", W'(e_nxt), W'(c[24]));
                check("t", W'(t), W'(c[23:16]));
                check("d", W'(d), W'(c[15:0]));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                logic [W:0] r;
                r = exp_q.pop_front();
                check("ac", ac, r[W:1]);
                check("e", W'(e), W'(r[0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        com_rst = 1'b1; en = 1'b0; dr = '0; inpr = '0; ops = '0;
        e_clr = 1'b0; e_cmp = 1'b0; ac_clr = 1'b0; ac_inr = 1'b0;
        sc = '0; dcode = '0; dec_en = 1'b0;
        m_ac = '0; m_e = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state held, nothing enabled.
        begin_cycle(); en = 1'b0; commit();

        // Reset beats en=0 with a loaded AC and E=1.
        begin_cycle(); dr = 32'h1234; ops[2] = 1'b1; e_cmp = 1'b1; commit();
        begin_cycle(); com_rst = 1'b1; en = 1'b0; ops[1] = 1'b1; commit();

        // Add with carry out.
        load_ac(32'hFFFF_FFFF);
        do_op(1, 32'h1);

        // Shift round trip through E.
        begin_cycle(); dr = 32'h8000_0001; ops[2] = 1'b1; e_clr = 1'b1; commit();
        do_op(6, '0);
        do_op(5, '0);

        // Multiply / divide, including divide by zero.
        load_ac(32'd7);
        do_op(7, 32'd6);
        do_op(8, 32'd5);
        do_op(8, 32'd0);

        // INPR into the low byte, upper bits preserved.
        load_ac(32'hABCD_1234);
        begin_cycle(); inpr = 8'h5A; ops[3] = 1'b1; commit();

        // Clear beats increment; increment wraps and leaves E alone.
        begin_cycle(); ac_clr = 1'b1; ac_inr = 1'b1; commit();
        begin_cycle(); dr = 32'hFFFF_FFFF; ops[2] = 1'b1; e_cmp = 1'b1; commit();
        begin_cycle(); ac_inr = 1'b1; commit();

        // e_clr wins over e_cmp.
        begin_cycle(); e_clr = 1'b1; e_cmp = 1'b1; commit();
        begin_cycle(); e_cmp = 1'b1; commit();
        begin_cycle(); e_clr = 1'b1; e_cmp = 1'b1; commit();

        // Frozen registers with every kind of strobe.
        load_ac(32'h0F0F_5555);
        for (int i = 0; i < 9; i++) begin
            begin_cycle(); en = 1'b0; ops[i] = 1'b1; e_cmp = 1'b1; ac_inr = 1'b1; commit();
        end

        // Decoder sweeps, enabled and disabled.
        for (int k = 0; k < 16; k++) begin
            begin_cycle(); sc = 3'(k); dcode = 4'(k); commit();
        end
        for (int k = 0; k < 8; k++) begin
            begin_cycle(); dec_en = 1'b0; sc = 3'(k); dcode = 4'(k + 8); commit();
        end

        // Random single-strobe traffic with occasional freezes and resets.
        for (int n = 0; n < 400; n++) begin
            int pick;
            begin_cycle();
            pick   = $urandom_range(0, 10);
            if (pick < 9) ops[pick] = 1'b1;
            if ($urandom_range(0, 7) == 0) dr = '0;
            if ($urandom_range(0, 7) == 0) dr = 32'($urandom_range(1, 9));
            e_clr  = ($urandom_range(0, 5) == 0);
            e_cmp  = ($urandom_range(0, 3) == 0);
            ac_clr = ($urandom_range(0, 15) == 0);
            ac_inr = ($urandom_range(0, 3) == 0);
            en     = ($urandom_range(0, 7) != 0);
            dec_en = ($urandom_range(0, 4) != 0);
            com_rst = ($urandom_range(0, 49) == 0);
            commit();
        end

        repeat (3) @(posedge clk);
        #3;
        check("queues_drained", W'(comb_q.size() + exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
